obj_ram_loader: RTL

Writer-side counterpart of the object bus: a DMA engine that fills the object data RAM with the sprite attribute table during vertical blank, replacing per-byte Z80 writes.
- Reads 128 bytes (32 objects × 4 bytes) from a work-RAM source port.
- Writes them into the object RAM write port, into the bank not currently being displayed.
- Applies the same byte-lane address swizzle the Z80 port uses.

---
 rtl/obj_pkg.sv | 20 ++
 rtl/obj_ram_loader_vbl_sync.sv | 30 +++
 rtl/obj_ram_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/obj_pkg.sv
// Shared object-RAM definitions: sizes, loader FSM states and the
// byte-lane swizzle used by both the Z80 port decode and the DMA loader.
package obj_pkg;

  localparam int OBJ_BYTES    = 128;
  localparam int OBJ_BANK_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WRITE,
    DONE
  } obj_state_t;

  // Logical lanes 0,1,2,3 land on physical lanes 3,0,1,2.
  function automatic logic [7:0] obj_swz(input logic [7:0] l);
    return {l[7:2], l[1] ^ ~l[0], ~l[0]};
  endfunction

endpackage

// File: rtl/obj_ram_loader_vbl_sync.sv
// VBL synchroniser: 2-flop sync of the async level plus rising-edge detect.
// Ports: clk, rst (async high), vbl (async in), vbl_s (sync level), vbl_rise.
module vbl_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic vbl,
  output logic vbl_s,
  output logic vbl_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= vbl;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign vbl_s    = r_s2;
  assign vbl_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/obj_ram_loader.sv
// Vblank DMA: copies the sprite attribute table from work RAM into the
// hidden object-RAM bank, using the same lane swizzle as the Z80 port.
// Ports: clkm_48MHZ/reset; en, VBL, OBJEX, cpu_busy controls;
// src_* work-RAM read handshake; ob_* object-RAM write port;
// busy, done pulse, sticky abort_err status.
module obj_ram_loader
  import obj_pkg::*;
#(
  parameter int          NUM_BYTES = OBJ_BYTES,
  parameter logic [15:0] SRC_BASE  = 16'hD000
) (
  input  logic        clkm_48MHZ,
  input  logic        reset,
  input  logic        en,
  input  logic        VBL,
  input  logic        OBJEX,
  input  logic        cpu_busy,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  input  logic        src_ack,
  output logic [7:0]  ob_addr,
  output logic [7:0]  ob_data,
  output logic        ob_we,
  output logic        busy,
  output logic        done,
  output logic        abort_err
);

  localparam logic [6:0] LAST = 7'(NUM_BYTES - 1);

  logic w_vbl_s;
  logic w_vbl_rise;

  obj_state_t  r_state;
  logic [6:0]  r_idx;
  logic        r_bank;
  logic [7:0]  r_data;
  logic [15:0] r_src_addr;
  logic        r_src_rd;
  logic [7:0]  r_ob_addr;
  logic [7:0]  r_ob_data;
  logic        r_ob_we;
  logic        r_busy;
  logic        r_done;
  logic        r_abort;

  vbl_edge_sync u_vbl (
    .clk      (clkm_48MHZ),
    .rst      (reset),
    .vbl      (VBL),
    .vbl_s    (w_vbl_s),
    .vbl_rise (w_vbl_rise)
  );

  always_ff @(posedge clkm_48MHZ or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_bank     <= 1'b0;
      r_data     <= '0;
      r_src_addr <= '0;
      r_src_rd   <= 1'b0;
      r_ob_addr  <= '0;
      r_ob_data  <= '0;
      r_ob_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_ob_we <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_vbl_rise && en) begin
            r_bank     <= ~OBJEX;
            r_idx      <= '0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b1;
            r_src_rd   <= 1'b1;
            r_src_addr <= SRC_BASE;
            r_state    <= REQ;
          end
        end
        REQ: begin
          // Losing vblank beats a same-cycle ack.
          if (!w_vbl_s) begin
            r_src_rd <= 1'b0;
            r_busy   <= 1'b0;
            r_abort  <= 1'b1;
            r_state  <= IDLE;
          end else if (src_ack) begin
            r_data   <= src_data;
            r_src_rd <= 1'b0;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (!w_vbl_s) begin
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
            r_state <= IDLE;
          end else if (!cpu_busy) begin
            r_ob_we   <= 1'b1;
            r_ob_data <= r_data;
            r_ob_addr <= obj_swz({r_bank, r_idx});
            if (r_idx == LAST) begin
              r_state <= DONE;
            end else begin
              r_idx      <= r_idx + 7'd1;
              r_src_addr <= SRC_BASE + {9'd0, r_idx} + 16'd1;
              r_src_rd   <= 1'b1;
              r_state    <= REQ;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign src_addr  = r_src_addr;
  assign src_rd    = r_src_rd;
  assign ob_addr   = r_ob_addr;
  assign ob_data   = r_ob_data;
  assign ob_we     = r_ob_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign abort_err = r_abort;

endmodule
